pipe_stage_reg: RTL

Parametrised inter-stage pipeline register, the general successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches. It carries a data bundle and a control bundle between two pipeline stages through a two-entry skid buffer with valid/ready handshaking, supporting stall (back-pressure) and flush (bubble insertion). Control bits are forced to zero whenever the stage holds no valid instruction, so a bubble can never assert RegWrite, MemWrite, Branch or Jump downstream. It also keeps a saturating count of stall cycles for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: a two-entry skid buffer with valid/ready handshaking,
// flush to bubble, control masking on empty stages and a saturating stall counter.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 13,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic in_fire;
    logic out_fire;

    // in_ready depends only on registered state, so out_ready never reaches upstream combinationally.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d     = ONE;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (in_fire) begin
                    state_d     = TWO;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush only resets occupancy; stale data is hidden by the ctrl mask.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && !flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
